// File: rtl/rmii_receive_deframer_pkg.sv
// rmii_receive_pkg
//   Shared definitions for the RMII receive deframer:
//   - state_t        : deframer states IDLE / PREAMBLE / DATA
//   - PREAMBLE_DIBIT : 2'b01 preamble dibit
//   - SFD_DIBIT      : 2'b11 start-of-frame-delimiter dibit
//   - CRC32_POLY     : Ethernet CRC-32 generator polynomial
//   - CRC32_RESIDUE  : shift-register value after a frame with a good FCS
//   - ERR_*          : bit positions of the individual frame error causes
package rmii_receive_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2
  } state_t;

  localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  SFD_DIBIT      = 2'b11;
  localparam logic [31:0] CRC32_POLY     = 32'h04C11DB7;
  localparam logic [31:0] CRC32_RESIDUE  = 32'hC704DD7B;

  localparam int ERR_RUNT  = 0;
  localparam int ERR_GIANT = 1;
  localparam int ERR_RX_ER = 2;
  localparam int ERR_ALIGN = 3;
  localparam int ERR_FCS   = 4;
  localparam int ERR_WIDTH = 5;

endpackage

// File: rtl/rmii_receive_deframer_crc32.sv
// ethernet_crc32_dibit
//   Registered Ethernet CRC-32 accumulator advancing two bits per clock.
//   Bits are consumed in wire order (dibit[0] first). The register is kept in
//   non-reflected form, so a frame ending in a correct FCS leaves the
//   register at CRC32_RESIDUE.
// Ports:
//   clock  : clock
//   reset  : asynchronous active-high reset
//   init   : load 0xFFFFFFFF (takes priority over update)
//   update : fold dibit into the CRC
//   dibit  : two data bits, bit 0 received first
//   crc    : current CRC register value
module ethernet_crc32_dibit
  import rmii_receive_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        init,
  input  logic        update,
  input  logic [1:0]  dibit,
  output logic [31:0] crc
);

  logic [31:0] crc_reg;
  logic [31:0] crc_next;

  function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
    return {c[30:0], 1'b0} ^ ((c[31] ^ b) ? CRC32_POLY : 32'h0);
  endfunction

  always_comb begin
    crc_next = crc_reg;
    if (init)
      crc_next = 32'hFFFFFFFF;
    else if (update)
      crc_next = crc_bit(crc_bit(crc_reg, dibit[0]), dibit[1]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) crc_reg <= 32'hFFFFFFFF;
    else       crc_reg <= crc_next;
  end

  assign crc = crc_reg;

endmodule

// File: rtl/rmii_receive_deframer.sv
// rmii_receive_deframer
//   RMII receive front end: registers RXD/CRS_DV/RX_ER, hunts preamble + SFD,
//   assembles bytes LSB-first and emits a 9-bit byte stream whose bit 8 marks
//   the last byte of a frame. One completed byte is always held back so that
//   the end-of-frame flag can be attached to it when the carrier drops.
// Ports:
//   clock, reset               : 50 MHz RMII clock, asynchronous active-high reset
//   rmii_receive_data[1:0]     : RXD
//   rmii_receive_data_enable   : CRS_DV
//   rmii_receive_data_error    : RX_ER
//   receive_data[8:0]          : [7:0] byte, [8] end-of-frame
//   receive_data_valid         : one-cycle strobe per byte
//   frame_done                 : pulse with the end-of-frame byte
//   frame_error                : runt/giant/RX_ER/misaligned/(FCS), valid with frame_done
//   frame_length[10:0]         : completed bytes, saturating at MAX_FRAME_BYTES
// Build option:
//   RMII_RECEIVE_FCS_CHECK_EN  : adds CRC-32 checking of the received FCS
module rmii_receive_deframer
  import rmii_receive_pkg::*;
#(
  parameter int MIN_FRAME_BYTES     = 64,
  parameter int MAX_FRAME_BYTES     = 1522,
  parameter int MIN_PREAMBLE_DIBITS = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  rmii_receive_data,
  input  logic        rmii_receive_data_enable,
  input  logic        rmii_receive_data_error,
  output logic [8:0]  receive_data,
  output logic        receive_data_valid,
  output logic        frame_done,
  output logic        frame_error,
  output logic [10:0] frame_length
);

  // Registered line samples; all decisions are made on these.
  logic [1:0] rx_data_reg;
  logic       rx_enable_reg;
  logic       rx_error_reg;

  state_t                 state_reg, state_next;
  logic [3:0]             preamble_count_reg, preamble_count_next;
  logic [1:0]             dibit_index_reg, dibit_index_next;
  logic [5:0]             shift_reg, shift_next;      // dibits 0..2 of the byte in progress
  logic [7:0]             held_reg, held_next;
  logic                   held_valid_reg, held_valid_next;
  logic [10:0]            byte_count_reg, byte_count_next;
  logic [ERR_WIDTH-1:0]   error_reg, error_next;      // sticky causes: RX_ER, giant

  logic [8:0]             data_next;
  logic                   valid_next;
  logic                   done_next;
  logic                   frame_error_next;
  logic [10:0]            length_next;

  logic [7:0]             byte_complete;
  logic [ERR_WIDTH-1:0]   error_final;
  logic                   fcs_bad;

`ifdef RMII_RECEIVE_FCS_CHECK_EN
  logic [31:0] crc_value;
  logic        crc_init;
  logic        crc_update;

  assign crc_init   = (state_reg == PREAMBLE) && (state_next == DATA);
  assign crc_update = (state_reg == DATA) && rx_enable_reg;

  ethernet_crc32_dibit u_crc (
    .clock  (clock),
    .reset  (reset),
    .init   (crc_init),
    .update (crc_update),
    .dibit  (rx_data_reg),
    .crc    (crc_value)
  );

  // The CRC register already includes the final FCS dibit when the carrier
  // drop is seen, so the check lands on the same cycle as frame_done.
  assign fcs_bad = (crc_value != CRC32_RESIDUE);
`else
  assign fcs_bad = 1'b0;
`endif

  assign byte_complete = {rx_data_reg, shift_reg};

  always_comb begin
    state_next          = state_reg;
    preamble_count_next = preamble_count_reg;
    dibit_index_next    = dibit_index_reg;
    shift_next          = shift_reg;
    held_next           = held_reg;
    held_valid_next     = held_valid_reg;
    byte_count_next     = byte_count_reg;
    error_next          = error_reg;
    data_next           = '0;
    valid_next          = 1'b0;
    done_next           = 1'b0;
    frame_error_next    = 1'b0;
    length_next         = '0;
    error_final         = '0;

    unique case (state_reg)
      IDLE: begin
        if (rx_enable_reg && rx_data_reg == PREAMBLE_DIBIT) begin
          state_next          = PREAMBLE;
          preamble_count_next = 4'd1;
        end
      end

      PREAMBLE: begin
        if (!rx_enable_reg) begin
          state_next = IDLE;
        end else if (rx_data_reg == PREAMBLE_DIBIT) begin
          if (preamble_count_reg != 4'd15)
            preamble_count_next = preamble_count_reg + 4'd1;
        end else if (rx_data_reg == SFD_DIBIT &&
                     preamble_count_reg >= 4'(MIN_PREAMBLE_DIBITS)) begin
          state_next       = DATA;
          dibit_index_next = 2'd0;
          held_valid_next  = 1'b0;
          byte_count_next  = '0;
          error_next       = '0;
        end else begin
          state_next = IDLE;
        end
      end

      DATA: begin
        if (rx_error_reg)
          error_next[ERR_RX_ER] = 1'b1;

        if (rx_enable_reg) begin
          dibit_index_next = dibit_index_reg + 2'd1;
          case (dibit_index_reg)
            2'd0:    shift_next[1:0] = rx_data_reg;
            2'd1:    shift_next[3:2] = rx_data_reg;
            2'd2:    shift_next[5:4] = rx_data_reg;
            default: begin
              if (byte_count_reg == 11'(MAX_FRAME_BYTES)) begin
                // Oversize: drop the byte, keep the held one for end of frame.
                error_next[ERR_GIANT] = 1'b1;
              end else begin
                byte_count_next = byte_count_reg + 11'd1;
                if (held_valid_reg) begin
                  data_next  = {1'b0, held_reg};
                  valid_next = 1'b1;
                end
                held_next       = byte_complete;
                held_valid_next = 1'b1;
              end
            end
          endcase
        end else begin
          // Carrier dropped: close the frame on the held byte (a partial
          // byte in progress is discarded and flagged as misalignment).
          state_next      = IDLE;
          held_valid_next = 1'b0;
          if (held_valid_reg) begin
            error_final            = error_next;
            error_final[ERR_RUNT]  = byte_count_reg < 11'(MIN_FRAME_BYTES);
            error_final[ERR_ALIGN] = dibit_index_reg != 2'd0;
            error_final[ERR_FCS]   = fcs_bad;
            data_next        = {1'b1, held_reg};
            valid_next       = 1'b1;
            done_next        = 1'b1;
            frame_error_next = |error_final;
            length_next      = byte_count_reg;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_data_reg        <= '0;
      rx_enable_reg      <= 1'b0;
      rx_error_reg       <= 1'b0;
      state_reg          <= IDLE;
      preamble_count_reg <= '0;
      dibit_index_reg    <= '0;
      shift_reg          <= '0;
      held_reg           <= '0;
      held_valid_reg     <= 1'b0;
      byte_count_reg     <= '0;
      error_reg          <= '0;
      receive_data       <= '0;
      receive_data_valid <= 1'b0;
      frame_done         <= 1'b0;
      frame_error        <= 1'b0;
      frame_length       <= '0;
    end else begin
      rx_data_reg        <= rmii_receive_data;
      rx_enable_reg      <= rmii_receive_data_enable;
      rx_error_reg       <= rmii_receive_data_error;
      state_reg          <= state_next;
      preamble_count_reg <= preamble_count_next;
      dibit_index_reg    <= dibit_index_next;
      shift_reg          <= shift_next;
      held_reg           <= held_next;
      held_valid_reg     <= held_valid_next;
      byte_count_reg     <= byte_count_next;
      error_reg          <= error_next;
      receive_data       <= data_next;
      receive_data_valid <= valid_next;
      frame_done         <= done_next;
      frame_error        <= frame_error_next;
      frame_length       <= length_next;
    end
  end

endmodule

// File: tb/tb_rmii_receive_deframer.sv
// tb_rmii_receive_deframer
//   Scoreboard bench for rmii_receive_deframer: each frame task pushes the
//   expected byte stream and end-of-frame status, a monitor pops and compares
//   every strobe. Honours RMII_RECEIVE_FCS_CHECK_EN for the FCS expectation.
module tb_rmii_receive_deframer;

  localparam int MIN_FRAME = 64;
  localparam int MAX_FRAME = 1522;
  localparam int MIN_PRE   = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  rmii_receive_data = 2'b00;
  logic        rmii_receive_data_enable = 1'b0;
  logic        rmii_receive_data_error = 1'b0;
  logic [8:0]  receive_data;
  logic        receive_data_valid;
  logic        frame_done;
  logic        frame_error;
  logic [10:0] frame_length;

  rmii_receive_deframer dut (
    .clock                    (clock),
    .reset                    (reset),
    .rmii_receive_data        (rmii_receive_data),
    .rmii_receive_data_enable (rmii_receive_data_enable),
    .rmii_receive_data_error  (rmii_receive_data_error),
    .receive_data             (receive_data),
    .receive_data_valid       (receive_data_valid),
    .frame_done               (frame_done),
    .frame_error              (frame_error),
    .frame_length             (frame_length)
  );

  always #10 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic [8:0]  exp_bytes [$];
  logic [11:0] exp_frames [$];   // {error, length}
  int          lat_mark = -1;
  bit          lat_checked = 1'b0;
  logic [8:0]  exp_b;
  logic [11:0] exp_f;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic drive(input logic en, input logic [1:0] d, input logic er);
    @(negedge clock);
    rmii_receive_data_enable = en;
    rmii_receive_data        = d;
    rmii_receive_data_error  = er;
  endtask

  // nbytes includes the 4 FCS bytes. rxer_byte/drop_byte < 0 disable those faults.
  task automatic send_frame(input int nbytes, input int pre_len, input int rxer_byte,
                            input int drop_byte, input int drop_idx,
                            input bit flip_fcs, input bit mark);
    logic [7:0]  data [$];
    logic [7:0]  cur;
    logic [31:0] crc;
    int          n_complete, emitted;
    bit          err, stop;
    data = {};
    crc  = 32'hFFFFFFFF;
    for (int i = 0; i < nbytes - 4; i++) begin
      data.push_back(8'($urandom_range(0, 255)));
      crc = crc ^ {24'h0, data[i]};
      for (int k = 0; k < 8; k++)
        crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
    end
    crc = ~crc;
    for (int i = 0; i < 4; i++) data.push_back(crc[8*i +: 8]);
    if (flip_fcs) data[nbytes-1] = data[nbytes-1] ^ 8'h01;

    if (pre_len >= MIN_PRE) begin
      n_complete = (drop_byte >= 0) ? drop_byte : nbytes;
      emitted    = (n_complete > MAX_FRAME) ? MAX_FRAME : n_complete;
      err = (emitted < MIN_FRAME) || (n_complete > MAX_FRAME) ||
            (rxer_byte >= 0) || (drop_byte >= 0);
`ifdef RMII_RECEIVE_FCS_CHECK_EN
      err = err || flip_fcs;
`endif
      for (int i = 0; i < emitted; i++)
        exp_bytes.push_back({1'(i == emitted - 1), data[i]});
      if (emitted > 0) exp_frames.push_back({err, 11'(emitted)});
    end

    for (int i = 0; i < pre_len; i++) drive(1'b1, 2'b01, 1'b0);
    drive(1'b1, 2'b11, 1'b0);
    if (pre_len >= MIN_PRE) begin
      stop = 1'b0;
      for (int b = 0; b < nbytes && !stop; b++) begin
        cur = data[b];
        for (int k = 0; k < 4 && !stop; k++) begin
          if (b == drop_byte && k == drop_idx) begin
            stop = 1'b1;
          end else begin
            drive(1'b1, cur[2*k +: 2], 1'(b == rxer_byte && k == 0));
            if (mark && b == 1 && k == 3) lat_mark = cyc;
          end
        end
      end
    end
    repeat (12) drive(1'b0, 2'b00, 1'b0);
  endtask

  // Output monitor / scoreboard consumer.
  always @(negedge clock) begin
    if (!reset) begin
      if (receive_data_valid) begin
        if (exp_bytes.size() == 0) begin
          check("stray_strobe", 32'(exp_bytes.size()), 32'd1);
        end else begin
          exp_b = exp_bytes.pop_front();
          if (lat_mark >= 0 && !lat_checked) begin
            check("first_byte_latency", 32'(cyc - lat_mark), 32'd2);
            lat_checked = 1'b1;
          end
          check("byte", 32'(receive_data), 32'(exp_b));
          check("frame_done", 32'(frame_done), 32'(exp_b[8]));
          if (exp_b[8]) begin
            if (exp_frames.size() == 0) begin
              check("stray_frame", 32'(exp_frames.size()), 32'd1);
            end else begin
              exp_f = exp_frames.pop_front();
              check("frame_error", 32'(frame_error), 32'(exp_f[11]));
              check("frame_length", 32'(frame_length), 32'(exp_f[10:0]));
              $display("frame end: length=%0d error=%0b", frame_length, frame_error);
            end
          end
        end
      end else if (frame_done) begin
        check("done_without_strobe", 32'(frame_done), 32'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] r0, r1, r2;
    repeat (3) @(negedge clock);
    check("reset_data", 32'(receive_data), 32'd0);
    check("reset_valid", 32'(receive_data_valid), 32'd0);
    check("reset_done", 32'(frame_done), 32'd0);
    check("reset_error", 32'(frame_error), 32'd0);
    check("reset_length", 32'(frame_length), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    send_frame(64,   8, -1, -1, 0, 1'b0, 1'b1);  // nominal, latency mark
    send_frame(64,   6, -1, -1, 0, 1'b0, 1'b0);  // short preamble: ignored
    send_frame(64,  10, -1, -1, 0, 1'b0, 1'b0);  // following frame received
    send_frame(40,   8, -1, -1, 0, 1'b0, 1'b0);  // runt
    send_frame(100,  8, 20, -1, 0, 1'b0, 1'b0);  // RX_ER at byte 20
    send_frame(64,   8, -1, -1, 0, 1'b0, 1'b0);  // sticky error cleared
    send_frame(100,  8, -1, 69, 2, 1'b0, 1'b0);  // carrier drop mid byte 70
    send_frame(1600, 8, -1, -1, 0, 1'b0, 1'b0);  // giant
    send_frame(64,  15, -1, -1, 0, 1'b1, 1'b0);  // corrupted FCS
    send_frame(65,   8, -1, -1, 0, 1'b0, 1'b0);  // just above minimum

    // Asynchronous reset in the middle of a frame.
    r0 = 8'($urandom_range(0, 255));
    r1 = 8'($urandom_range(0, 255));
    r2 = 8'($urandom_range(0, 255));
    exp_bytes.push_back({1'b0, r0});
    exp_bytes.push_back({1'b0, r1});
    for (int i = 0; i < 8; i++) drive(1'b1, 2'b01, 1'b0);
    drive(1'b1, 2'b11, 1'b0);
    for (int k = 0; k < 4; k++) drive(1'b1, r0[2*k +: 2], 1'b0);
    for (int k = 0; k < 4; k++) drive(1'b1, r1[2*k +: 2], 1'b0);
    for (int k = 0; k < 4; k++) drive(1'b1, r2[2*k +: 2], 1'b0);
    drive(1'b1, 2'b10, 1'b0);
    drive(1'b1, 2'b01, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    rmii_receive_data_enable = 1'b0;
    #1;
    check("midreset_valid", 32'(receive_data_valid), 32'd0);
    check("midreset_done", 32'(frame_done), 32'd0);
    check("midreset_data", 32'(receive_data), 32'd0);
    check("midreset_bytes_seen", 32'(exp_bytes.size()), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    send_frame(64, 8, -1, -1, 0, 1'b0, 1'b0);    // recovery after reset

    repeat (10) @(negedge clock);
    check("latency_observed", 32'(lat_checked), 32'd1);
    check("byte_queue_drained", 32'(exp_bytes.size()), 32'd0);
    check("frame_queue_drained", 32'(exp_frames.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
